// File: rtl/edge_rate_monitor.sv
// Per-channel edge/level counter over repeating measurement windows.
// Asynchronous probes are synchronised, then counted into saturating accumulators.
module edge_rate_monitor #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned GATE_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             sig_in,
  input  logic                          enable,
  input  logic [GATE_WIDTH-1:0]         gate_len,
  input  logic [1:0]                    mode,
  output logic [NUM_CH*CNT_WIDTH-1:0]   count,
  output logic [NUM_CH-1:0]             ovf,
  output logic                          valid,
  output logic                          busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t                  state_q;
  logic [NUM_CH-1:0]       sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]       prev_q;
  logic [NUM_CH-1:0]       sync_c;
  logic [NUM_CH-1:0]       ev_c;
  logic [GATE_WIDTH-1:0]   gctr_q;
  logic [GATE_WIDTH-1:0]   gate_len_q;
  logic [1:0]              mode_q;
  logic [CNT_WIDTH-1:0]    acc_q   [NUM_CH];
  logic [CNT_WIDTH-1:0]    acc_nxt_c [NUM_CH];
  logic [NUM_CH-1:0]       sat_q;
  logic [NUM_CH-1:0]       sat_nxt_c;
  logic                    last_c;

  // Synchroniser chain plus previous-sample flop; free-running in every state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_c = sync_q[SYNC_STAGES-1];
  assign last_c = (gctr_q == gate_len_q);

  // Event selection uses the mode captured at window start
  always_comb begin
    ev_c = '0;
    unique case (mode_q)
      2'd0:    ev_c = sync_c & ~prev_q;
      2'd1:    ev_c = ~sync_c & prev_q;
      2'd2:    ev_c = sync_c ^ prev_q;
      default: ev_c = sync_c;
    endcase
  end

  // Saturating increment and sticky overflow for this cycle
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      acc_nxt_c[i] = acc_q[i];
      sat_nxt_c[i] = sat_q[i];
      if (ev_c[i]) begin
        if (acc_q[i] == CNT_MAX) begin
          sat_nxt_c[i] = 1'b1;
        end else begin
          acc_nxt_c[i] = acc_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Window FSM with accumulators and registered result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gctr_q     <= '0;
      gate_len_q <= '0;
      mode_q     <= '0;
      sat_q      <= '0;
      count      <= '0;
      ovf        <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            state_q    <= GATE;
            busy       <= 1'b1;
            gctr_q     <= '0;
            gate_len_q <= gate_len;
            mode_q     <= mode;
            sat_q      <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              acc_q[i] <= '0;
            end
          end
        end
        GATE: begin
          if (last_c) begin
            valid <= 1'b1;
            ovf   <= sat_nxt_c;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              count[i*CNT_WIDTH +: CNT_WIDTH] <= acc_nxt_c[i];
              acc_q[i] <= '0;
            end
            sat_q  <= '0;
            gctr_q <= '0;
            if (enable) begin
              gate_len_q <= gate_len;
              mode_q     <= mode;
            end else begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end
          end else if (!enable) begin
            // Abort: drop the partial window, keep the last published result
            state_q <= IDLE;
            busy    <= 1'b0;
            gctr_q  <= '0;
            sat_q   <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              acc_q[i] <= '0;
            end
          end else begin
            gctr_q <= gctr_q + GATE_WIDTH'(1);
            sat_q  <= sat_nxt_c;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              acc_q[i] <= acc_nxt_c[i];
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_rate_monitor.sv
// Scoreboard bench for edge_rate_monitor: two instances (wide and 4-bit counters)
// share stimulus; a window-level reference model predicts raw event totals.
module tb_edge_rate_monitor;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CW_A   = 16;
  localparam int unsigned CW_B   = 4;
  localparam int unsigned GW     = 16;
  localparam int unsigned SS     = 2;

  typedef logic [NUM_CH*16-1:0] raw_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [NUM_CH-1:0]        sig_in;
  logic                     enable;
  logic [GW-1:0]            gate_len;
  logic [1:0]               mode;
  logic [NUM_CH*CW_A-1:0]   count_a;
  logic [NUM_CH-1:0]        ovf_a;
  logic                     valid_a, busy_a;
  logic [NUM_CH*CW_B-1:0]   count_b;
  logic [NUM_CH-1:0]        ovf_b;
  logic                     valid_b, busy_b;

  edge_rate_monitor #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW_A), .GATE_WIDTH(GW), .SYNC_STAGES(SS)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable), .gate_len(gate_len), .mode(mode),
    .count(count_a), .ovf(ovf_a), .valid(valid_a), .busy(busy_a));

  edge_rate_monitor #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW_B), .GATE_WIDTH(GW), .SYNC_STAGES(SS)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable), .gate_len(gate_len), .mode(mode),
    .count(count_b), .ovf(ovf_b), .valid(valid_b), .busy(busy_b));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: sampled input history plus per-window raw event totals
  logic [NUM_CH-1:0] hist[$];
  bit                m_in_gate;
  int                m_pos, m_len, m_mode;
  int                m_n[NUM_CH];
  raw_t              qa[$], qb[$];
  int                t = 0;
  int                sig_sel = 0;
  int                half[NUM_CH] = '{5, 3, 4, 7, 2, 6, 9, 11};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit ev_of(input int md, input bit c, input bit p);
    case (md)
      0:       return c & !p;
      1:       return !c & p;
      2:       return c ^ p;
      default: return c;
    endcase
  endfunction

  function automatic logic [127:0] exp_cnt(input raw_t r, input int cw);
    logic [127:0] v = '0;
    int unsigned mx = (32'd1 << cw) - 1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      int unsigned n = 32'(r[ch*16 +: 16]);
      int unsigned c = (n > mx) ? mx : n;
      for (int b = 0; b < cw; b++) v[ch*cw + b] = c[b];
    end
    return v;
  endfunction

  function automatic logic [127:0] exp_ovf(input raw_t r, input int cw);
    logic [127:0] v = '0;
    int unsigned mx = (32'd1 << cw) - 1;
    for (int ch = 0; ch < NUM_CH; ch++) v[ch] = (32'(r[ch*16 +: 16]) > mx);
    return v;
  endfunction

  task automatic model_reset();
    m_in_gate = 0;
    hist.delete();
    for (int i = 0; i < SS + 1; i++) hist.push_back('0);
    qa.delete();
    qb.delete();
  endtask

  task automatic model_start();
    m_in_gate = 1;
    m_pos = 0;
    m_len = int'(gate_len);
    m_mode = int'(mode);
    for (int ch = 0; ch < NUM_CH; ch++) m_n[ch] = 0;
  endtask

  // Predicts the effect of the coming rising edge given current inputs
  task automatic model_edge();
    logic [NUM_CH-1:0] c, p;
    raw_t r;
    c = hist[hist.size() - SS];
    p = hist[hist.size() - SS - 1];
    if (m_in_gate) begin
      for (int ch = 0; ch < NUM_CH; ch++) m_n[ch] += int'(ev_of(m_mode, c[ch], p[ch]));
      if (m_pos == m_len) begin
        for (int ch = 0; ch < NUM_CH; ch++) r[ch*16 +: 16] = 16'(m_n[ch]);
        qa.push_back(r);
        qb.push_back(r);
        if (enable) model_start();
        else m_in_gate = 0;
      end else if (!enable) begin
        m_in_gate = 0;
      end else begin
        m_pos++;
      end
    end else if (enable) begin
      model_start();
    end
    hist.push_back(sig_in);
    if (hist.size() > SS + 2) void'(hist.pop_front());
  endtask

  function automatic logic [NUM_CH-1:0] gen_sig();
    logic [NUM_CH-1:0] v = '0;
    case (sig_sel)
      0: for (int ch = 0; ch < NUM_CH; ch++) v[ch] = ((t / half[ch]) % 2) == 1;
      1: v = '1;
      2: v = NUM_CH'($urandom);
      default: v[1] = 1'b1;
    endcase
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    sig_in = gen_sig();
    t++;
    if (rst) model_edge();
    else model_reset();
    @(posedge clk);
    #1;
    chk("busy_a", 128'(busy_a), 128'(m_in_gate));
    chk("busy_b", 128'(busy_b), 128'(m_in_gate));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_pos(input string nm, input int pos);
    int k = 0;
    while (!(m_in_gate && m_pos == pos) && k < 1000) begin
      step();
      k++;
    end
    chk(nm, 128'(m_in_gate && m_pos == pos), 128'(1));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_count_a"}, 128'(count_a), '0);
    chk({nm, "_count_b"}, 128'(count_b), '0);
    chk({nm, "_ovf"}, 128'({ovf_a, ovf_b}), '0);
    chk({nm, "_valid_busy"}, 128'({valid_a, valid_b, busy_a, busy_b}), '0);
  endtask

  // Monitor: pops an expected window on each valid, otherwise results must hold
  logic [127:0] held_ca = '0, held_oa = '0, held_cb = '0, held_ob = '0;
  always @(negedge clk) begin
    raw_t r;
    if (rst !== 1'b1) begin
      held_ca = '0; held_oa = '0; held_cb = '0; held_ob = '0;
    end else begin
      if (valid_a) begin
        if (qa.size() == 0) chk("unexpected_valid_a", 128'(1), 128'(0));
        else begin
          r = qa.pop_front();
          held_ca = exp_cnt(r, CW_A);
          held_oa = exp_ovf(r, CW_A);
          chk("count_a", 128'(count_a), held_ca);
          chk("ovf_a", 128'(ovf_a), held_oa);
        end
      end else begin
        chk("hold_count_a", 128'(count_a), held_ca);
        chk("hold_ovf_a", 128'(ovf_a), held_oa);
      end
      if (valid_b) begin
        if (qb.size() == 0) chk("unexpected_valid_b", 128'(1), 128'(0));
        else begin
          r = qb.pop_front();
          held_cb = exp_cnt(r, CW_B);
          held_ob = exp_ovf(r, CW_B);
          chk("count_b", 128'(count_b), held_cb);
          chk("ovf_b", 128'(ovf_b), held_ob);
        end
      end else begin
        chk("hold_count_b", 128'(count_b), held_cb);
        chk("hold_ovf_b", 128'(ovf_b), held_ob);
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; gate_len = '0; mode = 2'd0; sig_in = '0;
    model_reset();
    #1 rst = 1'b0;
    #1 chk_all_zero("reset");
    run(3);
    rst = 1'b1;

    // Square waves of distinct periods; ch0 period 10
    sig_sel = 0; mode = 2'd0; gate_len = 16'd99; enable = 1'b1;
    run(450);
    mode = 2'd2;
    run(330);
    run_to_pos("reach_mid_mode", 40);
    mode = 2'd3;
    run(330);

    // Saturation boundary on the 4-bit instance
    sig_sel = 1; gate_len = 16'd31;
    run(140);
    gate_len = 16'd14;
    run(80);

    // Abort mid-window, then drop enable exactly in the last cycle
    sig_sel = 0; mode = 2'd0; gate_len = 16'd99;
    run_to_pos("reach_gctr50", 50);
    enable = 1'b0;
    run(20);
    enable = 1'b1;
    run(1);
    run_to_pos("reach_last", 99);
    enable = 1'b0;
    run(10);

    // One-cycle windows
    enable = 1'b1; gate_len = 16'd0; mode = 2'd3; sig_sel = 3;
    run(20);
    sig_sel = 0; mode = 2'd2;
    run(20);

    // Randomised mix of modes, lengths and enable drops
    sig_sel = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) gate_len = 16'($urandom_range(0, 20));
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if ($urandom_range(0, 199) == 0) sig_sel = $urandom_range(0, 3);
      step();
    end

    // Reset mid-window with inputs held high
    sig_sel = 1; mode = 2'd0; gate_len = 16'd99; enable = 1'b1;
    run(5);
    run_to_pos("reach_gctr30", 30);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("mid_reset");
    model_reset();
    run(3);
    rst = 1'b1;
    run(250);

    enable = 1'b0;
    run(5);
    chk("drain_qa", 128'(qa.size()), 128'(0));
    chk("drain_qb", 128'(qb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/edge_rate_monitor.md
EDGE_RATE_MONITOR -- requirements
Module: edge_rate_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of monitored channels (1..32).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, per-channel result width.
REQ-003 SHALL have parameter GATE_WIDTH, default 32, gate-length width.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth (>=2).
REQ-005 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous reset, active-low.
REQ-007 SHALL have port sig_in  in  NUM_CH  asynchronous probe inputs.
REQ-008 SHALL have port enable  in  1  run continuous measurement windows while high.
REQ-009 SHALL have port gate_len  in  GATE_WIDTH  window length minus one, in clk cycles.
REQ-010 SHALL have port mode  in  2  0 rising, 1 falling, 2 both edges, 3 high-level cycles.
REQ-011 SHALL have port count  out  NUM_CH*CNT_WIDTH  latched results, channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-012 SHALL have port ovf  out  NUM_CH  per-channel saturation flag for the latched window.
REQ-013 SHALL have port valid  out  1  one-cycle pulse: count/ovf updated.
REQ-014 SHALL have port busy  out  1  high while in GATE state.

Function
REQ-015 SHALL pass each sig_in bit through SYNC_STAGES flops, then a previous-sample flop; synchroniser and previous-sample flops update every cycle in all states.
REQ-016 SHALL derive per-channel event ev: mode 0 sync&~prev, 1 ~sync&prev, 2 sync^prev, 3 sync.
REQ-017 SHALL have states IDLE and GATE; IDLE->GATE when enable=1; GATE->IDLE when enable=0 (abort) or at window end with enable=0.
REQ-018 SHALL capture gate_len and mode into internal registers on every window start (IDLE->GATE and each back-to-back restart); changes mid-window have no effect.
REQ-019 SHALL run window cycle counter gctr from 0 to gate_len_q, i.e. window = gate_len_q+1 cycles; gate_len=0 gives 1-cycle window.
REQ-020 SHALL add ev to each channel accumulator every GATE cycle, including the first and last cycles.
REQ-021 SHALL saturate accumulators at 2^CNT_WIDTH-1; a per-channel sticky sat bit sets on any increment attempted at the maximum value.
REQ-022 SHALL, in the last window cycle (gctr==gate_len_q), load count <= sat(acc+ev), ovf <= sat bit incl. this cycle, and assert valid in the following cycle coincident with new count.
REQ-023 SHALL, at window end with enable=1, start the next window in the next cycle with no gap: acc and sat cleared, gctr=0, new gate_len/mode captured.
REQ-024 SHALL, on abort (enable=0 mid-window), discard acc, clear sat, emit no valid, and hold previous count/ovf.
REQ-025 SHALL, when enable falls in the last window cycle, still complete that window (valid asserted) and then go to IDLE.
REQ-026 SHALL exhibit latency of SYNC_STAGES+1 cycles from a sig_in transition at a clk edge to its event being counted.
REQ-027 SHALL keep busy high in exactly the GATE cycles.
REQ-028 SHALL treat all NUM_CH channels identically and independently; the window timing is shared.

Reset
REQ-029 SHALL, on rst low, asynchronously clear: state IDLE, gctr, acc, sat, count, ovf, valid, busy, synchroniser and previous-sample flops, captured gate_len/mode.
REQ-030 SHALL, if rst asserts mid-window, discard the window with no valid pulse; after release, a sig_in held high produces one rising event once it propagates through the synchroniser.
REQ-031 SHALL begin operation in the first cycle after rst deasserts if enable=1.

Verification
REQ-032 SHALL cover: ch0 square wave period 10 clk, mode 0, gate_len=99, steady state -> count[ch0]=10 per window, valid every 100 cycles, ovf=0.
REQ-033 SHALL cover: same stimulus, mode 2 -> count=20; mode 3 -> count=50; switching mode mid-window takes effect next window only.
REQ-034 SHALL cover: CNT_WIDTH=4, mode 3, sig_in all high, gate_len=31 -> every channel count=15, ovf=1; gate_len=14 -> count=15, ovf=0.
REQ-035 SHALL cover: enable dropped at gctr=50 -> no valid, count unchanged, busy low next cycle; enable dropped at gctr=gate_len -> valid once, then IDLE.
REQ-036 SHALL cover: gate_len=0, mode 3, ch1 high -> valid every cycle with count[ch1]=1; channels with distinct frequencies give independent correct counts.
REQ-037 SHALL cover: rst asserted mid-window -> all outputs 0 immediately; no valid until a full window completes after release.
